mem_bus_arbiter: RTL

- Two-requester arbiter that shares the single Avalon-style memory bus.
- Port 0 is the CPU bus master (mips_cpu_bus). Port 1 is a secondary master, e.g. the debug/program loader or a DMA engine.
- Grants the downstream bus to one master at a time.
- Holds the grant until that master's transfer completes, then re-arbitrates.

---
 rtl/mem_bus_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Function : Two-master arbiter for a shared Avalon-style memory bus.
//            Define ARB_ROUND_ROBIN_EN for round-robin on contention.
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   m0_address,
    input  logic            m0_read,
    input  logic            m0_write,
    input  logic [DW-1:0]   m0_writedata,
    input  logic [DW/8-1:0] m0_byteenable,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_waitrequest,
    input  logic [AW-1:0]   m1_address,
    input  logic            m1_read,
    input  logic            m1_write,
    input  logic [DW-1:0]   m1_writedata,
    input  logic [DW/8-1:0] m1_byteenable,
    output logic [DW-1:0]   m1_readdata,
    output logic            m1_waitrequest,
    output logic [AW-1:0]   address,
    output logic            read,
    output logic            write,
    output logic [DW-1:0]   writedata,
    output logic [DW/8-1:0] byteenable,
    input  logic [DW-1:0]   readdata,
    input  logic            waitrequest,
    output logic [1:0]      grant
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nx;
    logic   r_last_owner;
    logic   w_last_owner_nx;
    logic   w_m0_req;
    logic   w_m1_req;
    logic   w_pick1;

    assign w_m0_req = m0_read | m0_write;
    assign w_m1_req = m1_read | m1_write;

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        // On contention the port that did not complete last wins
        if (w_m0_req && w_m1_req) begin
            w_pick1 = ~r_last_owner;
        end else begin
            w_pick1 = ~w_m0_req;
        end
`else
        w_pick1 = ~w_m0_req;
`endif
    end

    always_comb begin
        w_state_nx      = r_state;
        w_last_owner_nx = r_last_owner;
        address         = '0;
        read            = 1'b0;
        write           = 1'b0;
        writedata       = '0;
        byteenable      = '0;
        grant           = 2'b00;
        m0_waitrequest  = 1'b1;
        m1_waitrequest  = 1'b1;
        m0_readdata     = '0;
        m1_readdata     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_m0_req || w_m1_req) begin
                    w_state_nx = w_pick1 ? S_OWN1 : S_OWN0;
                end
            end
            S_OWN0: begin
                grant          = 2'b01;
                address        = m0_address;
                read           = m0_read & ~m0_write;
                write          = m0_write;
                writedata      = m0_writedata;
                byteenable     = m0_byteenable;
                m0_waitrequest = waitrequest;
                m0_readdata    = readdata;
                if (!w_m0_req) begin
                    w_state_nx = S_IDLE;
                end else if (!waitrequest) begin
                    w_state_nx      = S_IDLE;
                    w_last_owner_nx = 1'b0;
                end
            end
            S_OWN1: begin
                grant          = 2'b10;
                address        = m1_address;
                read           = m1_read & ~m1_write;
                write          = m1_write;
                writedata      = m1_writedata;
                byteenable     = m1_byteenable;
                m1_waitrequest = waitrequest;
                m1_readdata    = readdata;
                if (!w_m1_req) begin
                    w_state_nx = S_IDLE;
                end else if (!waitrequest) begin
                    w_state_nx      = S_IDLE;
                    w_last_owner_nx = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nx;
            r_last_owner <= w_last_owner_nx;
        end
    end

endmodule
`default_nettype wire
